main_datapath: RTL and testbench

UART-driven 8-bit ALU datapath for board-level bring-up of the processor ALU. It receives a 3-byte command frame (opcode, operand A, operand B) on a UART RX pin and computes the result in a registered ALU. It returns the result byte on a UART TX pin and drives status LEDs and flags. It sits at the top level between the board UART pins and the LEDs.

---
 rtl/main_datapath.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_main_datapath.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_datapath.sv
// main_datapath
//   UART-driven 8-bit ALU for board bring-up. A 3-byte command frame
//   (opcode, A, B) arrives on the RX pin. The registered ALU result goes
//   back out on the TX pin, and status is shown on LEDs and flags.
//
// Ports
//   clk              system clock, all logic on its rising edge
//   reset            synchronous active-low reset
//   uartRxPin        UART RX, 8N1, LSB first, idle high, asynchronous
//   uartTxPin        UART TX, 8N1, LSB first, idle high
//   ALUzero          last result was zero (held until next execute)
//   ALUOverflow      signed overflow of last ADD/SUB (held until next execute)
//   ledIdle          waiting for an opcode and no RX start bit in progress
//   sentFlag         one-cycle pulse after the result stop bit completes
//   notStartUartTx   active-low one-cycle TX start strobe
//   ledDataAvailable result latched and not yet fully transmitted
//   sendCounter      number of result bytes sent, wraps at 256
//
// Control FSM
//   state    | meaning
//   WAIT_OP  | waiting for opcode byte
//   WAIT_A   | waiting for operand A
//   WAIT_B   | waiting for operand B
//   EXEC     | result and flags registered, data available
//   START_TX | start strobe low, TX shifter loads result
//   WAIT_TX  | result byte being shifted out
module main_datapath #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uartRxPin,
  output logic       uartTxPin,
  output logic       ALUzero,
  output logic       ALUOverflow,
  output logic       ledIdle,
  output logic       sentFlag,
  output logic       notStartUartTx,
  output logic       ledDataAvailable,
  output logic [7:0] sendCounter
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_OP, WAIT_A, WAIT_B, EXEC, START_TX, WAIT_TX} ctl_state_t;

  // RX
  rx_state_t     r_rx_state;
  logic          r_rx_sync1;
  logic          r_rx_sync2;
  logic          r_rx_sync3;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx_shift;
  logic          r_rx_done;
  logic          r_rx_err;

  // control
  ctl_state_t    r_state;
  logic [7:0]    r_op;
  logic [7:0]    r_a;
  logic [7:0]    r_result;
  logic          r_zero;
  logic          r_ovf;
  logic          r_lda;
  logic          r_sent;
  logic          r_nstart;
  logic [7:0]    r_send_cnt;

  // TX
  logic          r_tx_busy;
  logic          r_tx_pin;
  logic [8:0]    r_tx_shift;
  logic [3:0]    r_tx_left;
  logic [CW-1:0] r_tx_cnt;

  logic [7:0]    w_b;
  logic [7:0]    w_add;
  logic [7:0]    w_sub;
  logic [7:0]    w_alu_res;
  logic          w_alu_ovf;
  logic          w_tx_done;

  // The received byte stays in the shifter until the next data bit, so it
  // is still valid in the cycle rx_done is high.
  assign w_b   = r_rx_shift;
  assign w_add = r_a + w_b;
  assign w_sub = r_a - w_b;

  // Operand B feeds the ALU straight from the receiver so the result and
  // flags are already registered while the FSM sits in EXEC.
  always_comb begin
    w_alu_res = 8'h00;
    w_alu_ovf = 1'b0;
    if (r_op[7:3] == 5'd0) begin
      case (r_op[2:0])
        3'd0: begin
          w_alu_res = w_add;
          w_alu_ovf = (r_a[7] == w_b[7]) && (w_add[7] != r_a[7]);
        end
        3'd1: begin
          w_alu_res = w_sub;
          w_alu_ovf = (r_a[7] != w_b[7]) && (w_sub[7] != r_a[7]);
        end
        3'd2:    w_alu_res = r_a & w_b;
        3'd3:    w_alu_res = r_a | w_b;
        3'd4:    w_alu_res = r_a ^ w_b;
        3'd5:    w_alu_res = $unsigned($signed(r_a) >>> w_b[2:0]);
        3'd6:    w_alu_res = r_a >> w_b[2:0];
        default: w_alu_res = ~(r_a | w_b);
      endcase
    end
  end

  // Receiver. Start is a falling edge on the synchronized line so a frame
  // that ends with a low stop bit cannot immediately retrigger.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_sync3 <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_done  <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_sync1 <= uartRxPin;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_sync3 <= r_rx_sync2;
      r_rx_done  <= 1'b0;
      r_rx_err   <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_sync3 && !r_rx_sync2) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (r_rx_cnt == '0) begin
            if (!r_rx_sync2) begin
              r_rx_state <= RX_DATA;
              r_rx_cnt   <= BIT_LAST;
              r_rx_idx   <= '0;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
            r_rx_cnt   <= BIT_LAST;
            if (r_rx_idx == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == '0) begin
            if (r_rx_sync2) begin
              r_rx_done <= 1'b1;
            end else begin
              r_rx_err <= 1'b1;
            end
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Last cycle of the stop bit.
  assign w_tx_done = r_tx_busy && (r_tx_cnt == '0) && (r_tx_left == 4'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= WAIT_OP;
      r_op       <= 8'h00;
      r_a        <= 8'h00;
      r_result   <= 8'h00;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_lda      <= 1'b0;
      r_sent     <= 1'b0;
      r_nstart   <= 1'b1;
      r_send_cnt <= 8'h00;
    end else begin
      r_sent   <= 1'b0;
      r_nstart <= 1'b1;
      case (r_state)
        WAIT_OP: begin
          if (r_rx_done) begin
            r_op    <= w_b;
            r_state <= WAIT_A;
          end
        end
        WAIT_A: begin
          if (r_rx_done) begin
            r_a     <= w_b;
            r_state <= WAIT_B;
          end else if (r_rx_err) begin
            r_state <= WAIT_OP;
          end
        end
        WAIT_B: begin
          if (r_rx_done) begin
            r_result <= w_alu_res;
            r_zero   <= (w_alu_res == 8'h00);
            r_ovf    <= w_alu_ovf;
            r_lda    <= 1'b1;
            r_state  <= EXEC;
          end else if (r_rx_err) begin
            r_state <= WAIT_OP;
          end
        end
        EXEC: begin
          r_nstart <= 1'b0;
          r_state  <= START_TX;
        end
        START_TX: r_state <= WAIT_TX;
        WAIT_TX: begin
          if (w_tx_done) begin
            r_sent     <= 1'b1;
            r_send_cnt <= r_send_cnt + 8'd1;
            r_lda      <= 1'b0;
            r_state    <= WAIT_OP;
          end
        end
        default: r_state <= WAIT_OP;
      endcase
    end
  end

  // Transmitter: start bit goes out on load, then 8 data bits and the stop
  // bit from the shifter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_busy  <= 1'b0;
      r_tx_pin   <= 1'b1;
      r_tx_shift <= '0;
      r_tx_left  <= 4'd0;
      r_tx_cnt   <= '0;
    end else if (r_state == START_TX) begin
      r_tx_busy  <= 1'b1;
      r_tx_pin   <= 1'b0;
      r_tx_shift <= {1'b1, r_result};
      r_tx_left  <= 4'd9;
      r_tx_cnt   <= BIT_LAST;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == '0) begin
        if (r_tx_left == 4'd0) begin
          r_tx_busy <= 1'b0;
          r_tx_pin  <= 1'b1;
        end else begin
          r_tx_pin   <= r_tx_shift[0];
          r_tx_shift <= {1'b0, r_tx_shift[8:1]};
          r_tx_left  <= r_tx_left - 4'd1;
          r_tx_cnt   <= BIT_LAST;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt - 1'b1;
      end
    end
  end

  assign uartTxPin        = r_tx_pin;
  assign ALUzero          = r_zero;
  assign ALUOverflow      = r_ovf;
  assign ledIdle          = (r_state == WAIT_OP) && (r_rx_state == RX_IDLE);
  assign sentFlag         = r_sent;
  assign notStartUartTx   = r_nstart;
  assign ledDataAvailable = r_lda;
  assign sendCounter      = r_send_cnt;

endmodule

// File: tb/tb_main_datapath.sv
module tb_main_datapath;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       uartTxPin;
  logic       ALUzero;
  logic       ALUOverflow;
  logic       ledIdle;
  logic       sentFlag;
  logic       notStartUartTx;
  logic       ledDataAvailable;
  logic [7:0] sendCounter;

  main_datapath #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .uartRxPin(rx),
    .uartTxPin(uartTxPin),
    .ALUzero(ALUzero),
    .ALUOverflow(ALUOverflow),
    .ledIdle(ledIdle),
    .sentFlag(sentFlag),
    .notStartUartTx(notStartUartTx),
    .ledDataAvailable(ledDataAvailable),
    .sendCounter(sendCounter)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // expected results, packed as {result, zero, overflow}
  logic [9:0] exp_q[$];
  bit         tx_active = 1'b0;
  int         s_cyc = 0;
  int         cyc = 0;
  int         pos = 0;
  logic [9:0] cur = '0;
  logic [9:0] frame_bits = '0;
  int         exp_cnt = 0;
  int         n_starts = 0;
  int         n_sent = 0;
  logic       rst_prev = 1'b0;
  logic       lda_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] alu_ref(input logic [7:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int sa, sb, r;
    logic ovf;
    logic [7:0] res;
    sa = int'(a);
    sb = int'(b);
    if (sa >= 128) sa = sa - 256;
    if (sb >= 128) sb = sb - 256;
    ovf = 1'b0;
    r = 0;
    if (op <= 8'd7) begin
      case (op)
        8'd0: begin r = sa + sb; ovf = (r > 127) || (r < -128); end
        8'd1: begin r = sa - sb; ovf = (r > 127) || (r < -128); end
        8'd2: r = int'(a & b);
        8'd3: r = int'(a | b);
        8'd4: r = int'(a ^ b);
        8'd5: r = sa >>> int'(b % 8);
        8'd6: r = int'(a) / (1 << int'(b % 8));
        default: r = 255 - int'(a | b);
      endcase
    end
    res = r[7:0];
    return {res, (res == 8'h00), ovf};
  endfunction

  // Per-cycle comparison against the expected-result queue and UART framing.
  always @(negedge clk) begin
    cyc++;
    if (!rst_prev) begin
      chk("rst_txpin", uartTxPin, 1);
      chk("rst_zero", ALUzero, 0);
      chk("rst_ovf", ALUOverflow, 0);
      chk("rst_idle", ledIdle, 1);
      chk("rst_sent", sentFlag, 0);
      chk("rst_nstart", notStartUartTx, 1);
      chk("rst_lda", ledDataAvailable, 0);
      chk("rst_count", sendCounter, 0);
      exp_q.delete();
      tx_active = 1'b0;
      exp_cnt = 0;
    end else if (tx_active) begin
      pos = cyc - s_cyc;
      if (pos <= 10 * CPB) begin
        chk("tx_bit", uartTxPin, frame_bits[(pos - 1) / CPB]);
        chk("tx_nstart_hi", notStartUartTx, 1);
        chk("tx_sent_lo", sentFlag, 0);
        chk("tx_lda", ledDataAvailable, 1);
        chk("tx_idle_lo", ledIdle, 0);
      end else begin
        exp_cnt = (exp_cnt + 1) % 256;
        chk("sent_pulse", sentFlag, 1);
        chk("send_count", sendCounter, exp_cnt);
        chk("lda_clear", ledDataAvailable, 0);
        chk("end_nstart", notStartUartTx, 1);
        chk("zero_hold", ALUzero, cur[1]);
        chk("ovf_hold", ALUOverflow, cur[0]);
        chk("end_pin", uartTxPin, 1);
        n_sent++;
        tx_active = 1'b0;
      end
    end else if (notStartUartTx === 1'b0) begin
      n_starts++;
      chk("tx_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        frame_bits = {1'b1, cur[9:2], 1'b0};
        chk("exec_lda", lda_prev, 1);
        chk("start_lda", ledDataAvailable, 1);
        chk("start_zero", ALUzero, cur[1]);
        chk("start_ovf", ALUOverflow, cur[0]);
        chk("start_sent", sentFlag, 0);
        chk("start_pin", uartTxPin, 1);
        tx_active = 1'b1;
        s_cyc = cyc;
      end
    end else begin
      chk("idle_pin", uartTxPin, 1);
      chk("idle_sent", sentFlag, 0);
      chk("idle_lda", lda_prev, 0);
    end
    rst_prev = reset;
    lda_prev = ledDataAvailable;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30 * CPB + 60; i++) begin
      if (exp_q.size() == 0 && !tx_active) begin
        done = 1'b1;
        break;
      end
      tick(1);
    end
    chk("frame_done", done, 1);
    tick(2);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [9:0] e);
    send_byte(op, 1'b1);
    tick($urandom_range(0, 3));
    send_byte(a, 1'b1);
    tick($urandom_range(0, 3));
    exp_q.push_back(e);
    send_byte(b, 1'b1);
    wait_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st0, se0;
    bit seen;
    logic [7:0] op, a, b;

    // reset held for two cycles
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    chk("reset_txpin", uartTxPin, 1);
    chk("reset_idle", ledIdle, 1);
    chk("reset_count", sendCounter, 8'h00);
    chk("reset_nstart", notStartUartTx, 1);
    chk("reset_zero", ALUzero, 0);
    chk("reset_ovf", ALUOverflow, 0);
    tick(3);

    // model pinned by hand-computed values
    chk("ref_add_ovf", alu_ref(8'h00, 8'h7F, 8'h01), {8'h80, 1'b0, 1'b1});
    chk("ref_sub_zero", alu_ref(8'h01, 8'h55, 8'h55), {8'h00, 1'b1, 1'b0});
    chk("ref_sra", alu_ref(8'h05, 8'h80, 8'h03), {8'hF0, 1'b0, 1'b0});
    chk("ref_bad_op", alu_ref(8'h09, 8'h12, 8'h34), {8'h00, 1'b1, 1'b0});
    chk("ref_sub_ovf", alu_ref(8'h01, 8'h80, 8'h01), {8'h7F, 1'b0, 1'b1});

    // ADD with signed overflow
    st0 = n_starts;
    se0 = n_sent;
    send_frame(8'h00, 8'h7F, 8'h01, {8'h80, 1'b0, 1'b1});
    chk("add_ovf", ALUOverflow, 1);
    chk("add_zero", ALUzero, 0);
    chk("add_count", sendCounter, 8'd1);
    chk("add_one_start", n_starts - st0, 1);
    chk("add_one_sent", n_sent - se0, 1);
    chk("add_idle", ledIdle, 1);

    // SUB to zero, SRA, unknown opcode
    send_frame(8'h01, 8'h55, 8'h55, {8'h00, 1'b1, 1'b0});
    chk("sub_zero", ALUzero, 1);
    chk("sub_ovf", ALUOverflow, 0);
    send_frame(8'h05, 8'h80, 8'h03, {8'hF0, 1'b0, 1'b0});
    send_frame(8'h09, 8'h12, 8'h34, {8'h00, 1'b1, 1'b0});
    chk("badop_zero", ALUzero, 1);

    // quarter-bit glitch is a false start
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(3);
    chk("glitch_busy", ledIdle, 0);
    tick(4 * CPB);
    chk("glitch_idle", ledIdle, 1);
    send_frame(8'h04, 8'hA5, 8'h0F, {8'hAA, 1'b0, 1'b0});

    // bad stop bit in third byte discards the partial frame
    send_byte(8'h02, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h03, 1'b0);
    tick(2 * CPB);
    chk("ferr_idle", ledIdle, 1);
    send_frame(8'h03, 8'h12, 8'h21, {8'h33, 1'b0, 1'b0});

    // randomized frames
    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      send_frame(op, a, b, alu_ref(op, a, b));
    end
    chk("rand_count", sendCounter, 8'(n_sent));

    // reset in the middle of a transmission of 0x00
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    exp_q.push_back({8'h00, 1'b1, 1'b0});
    send_byte(8'h55, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 * CPB; i++) begin
      if (tx_active) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    chk("midtx_started", seen, 1);
    tick(5 * CPB);
    chk("midtx_low", uartTxPin, 0);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("midtx_pin", uartTxPin, 1);
    chk("midtx_count", sendCounter, 8'h00);
    chk("midtx_lda", ledDataAvailable, 0);
    tick(3 * CPB);

    // 256 ADD frames wrap the send counter
    for (int k = 0; k < 256; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      send_frame(8'h00, a, b, alu_ref(8'h00, a, b));
    end
    chk("wrap_count", sendCounter, 8'h00);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
